sevenseg_scan_ctrl: RTL

//  Parametrised multiplexed 7-segment driver for the lift status panel.
//  - Scans NUM_DIGITS digits; each digit carries a 5-bit glyph code (hex, lift glyphs, blank).
//  - Adds anti-ghosting guard time, per-digit blink, per-digit decimal point and tear-free updates.
//  - Sits between the lift controller FSM (floor, direction, door, music codes) and the board pins.

---
 rtl/sevenseg_scan_ctrl_if.sv | 25 ++
 rtl/sevenseg_scan_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_ctrl_if.sv
// Bus between the lift controller and the 7-segment scan driver.
// The controller side is the master; the scan driver is the slave.
interface sevenseg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      enable;
  logic                      load;
  logic [5*NUM_DIGITS-1:0]   code_in;
  logic [NUM_DIGITS-1:0]     blink_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [6:0]                seg;
  logic                      dp;
  logic [NUM_DIGITS-1:0]     an;
  logic                      frame_done;

  modport master (
    output enable, load, code_in, blink_in, dp_in,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  enable, load, code_in, blink_in, dp_in,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed 7-segment driver for the lift status panel: guarded digit scan,
// per-digit blink and decimal point, and double-buffered frame-aligned updates.
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_TICKS = 16384,
  parameter int GUARD_TICKS = 256,
  parameter int BLINK_TICKS = 25000000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  sevenseg_scan_ctrl_if.slave  bus
);

  localparam int TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic            POL        = (ACTIVE_LOW != 0);
  localparam logic [TW-1:0]   TICK_LAST  = TW'(DIGIT_TICKS - 1);
  localparam logic [TW-1:0]   GUARD_END  = TW'(GUARD_TICKS);
  localparam logic [IW-1:0]   IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_TICKS - 1);

  typedef logic [NUM_DIGITS-1:0][4:0] codes_t;

  // Active-high {g,f,e,d,c,b,a} pattern for a glyph code; 22..31 are blank.
  function automatic logic [6:0] glyph(input logic [4:0] code);
    logic [6:0] g;
    case (code)
      5'd0:    g = 7'h3F;
      5'd1:    g = 7'h06;
      5'd2:    g = 7'h5B;
      5'd3:    g = 7'h4F;
      5'd4:    g = 7'h66;
      5'd5:    g = 7'h6D;
      5'd6:    g = 7'h7D;
      5'd7:    g = 7'h07;
      5'd8:    g = 7'h7F;
      5'd9:    g = 7'h6F;
      5'd10:   g = 7'h77;
      5'd11:   g = 7'h7C;
      5'd12:   g = 7'h39;
      5'd13:   g = 7'h5E;
      5'd14:   g = 7'h79;
      5'd15:   g = 7'h71;
      5'd16:   g = 7'h54;
      5'd17:   g = 7'h3F;
      5'd18:   g = 7'h39;
      5'd19:   g = 7'h3E;
      5'd20:   g = 7'h5E;
      5'd21:   g = 7'h40;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  logic [TW-1:0]          tick_q, tick_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
  logic                   blink_on_q, blink_on_d;
  codes_t                 act_code_q, act_code_d, pend_code_q, pend_code_d;
  logic [NUM_DIGITS-1:0]  act_blink_q, act_blink_d, pend_blink_q, pend_blink_d;
  logic [NUM_DIGITS-1:0]  act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]  an_q, an_d;
  logic                   frame_done_q, frame_done_d;

  logic                   boundary_s;
  logic [4:0]             code_sel_s;
  logic [6:0]             seg_on_s;
  logic                   dp_on_s;
  logic [NUM_DIGITS-1:0]  an_on_s;

  assign boundary_s = bus.enable && (tick_q == TICK_LAST) && (idx_q == IDX_LAST);
  assign code_sel_s = act_code_q[idx_q];

  // Next-state for scan counters, blink timebase, display banks and outputs.
  always_comb begin
    tick_d       = tick_q;
    idx_d        = idx_q;
    blink_cnt_d  = blink_cnt_q;
    blink_on_d   = blink_on_q;
    act_code_d   = act_code_q;
    act_blink_d  = act_blink_q;
    act_dp_d     = act_dp_q;
    pend_code_d  = pend_code_q;
    pend_blink_d = pend_blink_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    seg_on_s     = 7'd0;
    dp_on_s      = 1'b0;
    an_on_s      = '0;

    if (bus.enable) begin
      if (tick_q == TICK_LAST) begin
        tick_d = TW'(0);
        idx_d  = (idx_q == IDX_LAST) ? IW'(0) : idx_q + IW'(1);
      end else begin
        tick_d = tick_q + TW'(1);
      end
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = BW'(0);
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end else begin
      tick_d = tick_q;
    end

    // A load landing on the boundary itself bypasses the pending bank.
    if (boundary_s) begin
      if (bus.load) begin
        act_code_d  = codes_t'(bus.code_in);
        act_blink_d = bus.blink_in;
        act_dp_d    = bus.dp_in;
      end else if (pend_valid_q) begin
        act_code_d  = pend_code_q;
        act_blink_d = pend_blink_q;
        act_dp_d    = pend_dp_q;
      end else begin
        act_code_d  = act_code_q;
      end
      pend_valid_d = 1'b0;
    end else if (bus.load) begin
      pend_code_d  = codes_t'(bus.code_in);
      pend_blink_d = bus.blink_in;
      pend_dp_d    = bus.dp_in;
      pend_valid_d = 1'b1;
    end else begin
      pend_valid_d = pend_valid_q;
    end

    // Blank glyphs keep the whole digit dark, anode included.
    if (!bus.enable) begin
      an_on_s = '0;
    end else if (tick_q < GUARD_END) begin
      an_on_s = '0;
    end else if (code_sel_s >= 5'd22) begin
      an_on_s = '0;
    end else begin
      an_on_s[idx_q] = 1'b1;
      if (act_blink_q[idx_q] && !blink_on_q) begin
        seg_on_s = 7'd0;
      end else begin
        seg_on_s = glyph(code_sel_s);
        dp_on_s  = act_dp_q[idx_q];
      end
    end

    seg_d        = seg_on_s ^ {7{POL}};
    dp_d         = dp_on_s ^ POL;
    an_d         = an_on_s ^ {NUM_DIGITS{POL}};
    frame_done_d = boundary_s;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q       <= TW'(0);
      idx_q        <= IW'(0);
      blink_cnt_q  <= BW'(0);
      blink_on_q   <= 1'b1;
      act_code_q   <= {NUM_DIGITS{5'd31}};
      act_blink_q  <= '0;
      act_dp_q     <= '0;
      pend_code_q  <= {NUM_DIGITS{5'd31}};
      pend_blink_q <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      seg_q        <= {7{POL}};
      dp_q         <= POL;
      an_q         <= {NUM_DIGITS{POL}};
      frame_done_q <= 1'b0;
    end else begin
      tick_q       <= tick_d;
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      act_code_q   <= act_code_d;
      act_blink_q  <= act_blink_d;
      act_dp_q     <= act_dp_d;
      pend_code_q  <= pend_code_d;
      pend_blink_q <= pend_blink_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule
